ct_lsu_pfu_pfb_mmu_pe_arb: RTL
==============================

Name: ct_lsu_pfu_pfb_mmu_pe_arb

Overview:
Responder and arbiter on the other end of the per-entry prefetch-buffer MMU page-entry request interface. It collects entry_mmu_pe_req from all PFB entries and picks one round-robin. It grants the winner and issues a single outstanding translation request to the MMU. The translation result is returned to the winning entry as a one-hot response, which the entries use to refill their page info.

Parameters:
ENTRY_NUM, 8, number of PFB entries (power of two)
ID_W, 3, log2(ENTRY_NUM)

Ports:
entry_clk  in  1  gated LSU PFU clock
cpurst_b  in  1  asynchronous active-low reset
entry_mmu_pe_req  in  ENTRY_NUM  per-entry request level
entry_mmu_pe_req_src  in  2*ENTRY_NUM  per-entry {l2,l1} source bits, entry i at [2i+1:2i]
entry_inst_new_va  in  40*ENTRY_NUM  per-entry prefetch VA, entry i at [40i+39:40i]
entry_priv_mode  in  2*ENTRY_NUM  per-entry privilege mode
entry_pop_vld  in  ENTRY_NUM  entry being popped or invalidated
pfu_pfb_flush  in  1  global PFB flush
entry_mmu_pe_req_grnt  out  ENTRY_NUM  one-cycle grant pulse, one-hot
pfu_mmu_req  out  1  translation request valid
pfu_mmu_vpn  out  28  VA[39:12] of the latched request
pfu_mmu_priv_mode  out  2  latched privilege mode
mmu_pfu_ack  in  1  MMU accepted the request
mmu_pfu_resp_vld  in  1  translation result valid, one cycle
mmu_pfu_ppn  in  28  physical page number
mmu_pfu_fault  in  1  page fault or access fault
pe_resp_vld  out  1  response pulse to entries
pe_resp_entry_oh  out  ENTRY_NUM  target entry, one-hot
pe_resp_src  out  2  latched src bits
pe_resp_ppn  out  28  registered PPN
pe_resp_fault  out  1  registered fault
arb_busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state IDLE; all outputs 0.
  - rr_ptr = ENTRY_NUM-1, so entry 0 wins first.
  - latched id/va/priv/src = 0; cancel flag 0.
- States:
  - IDLE (00), REQ (01), WAIT (10). Encoding 11 is illegal and goes to IDLE.
- IDLE:
  - Valid request vector = entry_mmu_pe_req & ~entry_pop_vld, masked to 0 if pfu_pfb_flush.
  - If the vector is nonzero, pick the first set bit searching from rr_ptr+1 upward, wrapping modulo ENTRY_NUM.
  - Latch winner id, VA[39:12], priv, src. Set rr_ptr to the winner id. Go to REQ.
  - entry_mmu_pe_req_grnt is registered: it is high for exactly the first REQ cycle, on the winner bit only.
- REQ:
  - pfu_mmu_req = 1 with stable vpn and priv until mmu_pfu_ack is sampled high.
  - On ack, go to WAIT.
  - Requests from entries are ignored in REQ and WAIT, so there is exactly one outstanding request.
- WAIT:
  - On mmu_pfu_resp_vld, go to IDLE.
  - Next cycle: pe_resp_vld = ~cancel, with entry_oh, src, ppn and fault registered.
  - Clear cancel when returning to IDLE.
  - A response in the same cycle as ack (REQ) is illegal; the MMU guarantees resp at least one cycle after ack.
- Cancel:
  - Set cancel if, in REQ or WAIT, entry_pop_vld[latched id] or pfu_pfb_flush.
  - The handshake still completes (req held until ack, response awaited), but no pe_resp_vld is produced.
  - Cancel takes effect in the same cycle as resp_vld if both coincide.
- Back-to-back:
  - Earliest re-arbitration is the IDLE cycle after the response, so minimum per-request occupancy is 3 cycles plus MMU latency.
- Simultaneous pop and request in IDLE:
  - The popped entry is excluded from arbitration.
- Reset mid-operation:
  - Asynchronous return to IDLE, all outputs 0 immediately.
  - The MMU side is reset by the same cpurst_b.
- Width rules:
  - VPN = entry VA[39:12].
  - src passes through unchanged.
  - entry_oh = 1 << latched id.

Test Plan:
- Single request: after reset, entry 3 req with src=2'b01, VA=40'h12_3456_7000. Required: grnt[3] pulse at cycle+1, pfu_mmu_req=1 with vpn=28'h1234567. Drive ack, then resp (ppn=28'hABCDE, fault=0). Required: pe_resp_vld=1 for one cycle, entry_oh=8'h08, src=01, ppn=28'hABCDE.
- Round-robin: entries 0, 2 and 5 hold req continuously, and each request completes. Required grant order: 0, 2, 5, 0. No entry is granted twice while another is pending.
- Stalled ack: hold mmu_pfu_ack=0 for 10 cycles. Required: pfu_mmu_req stays 1 with vpn and priv stable for all 10 cycles, and no second grant is issued.
- Cancel by pop: pop the latched entry during WAIT. Required: on resp_vld, state returns to IDLE and pe_resp_vld stays 0. The next request is accepted normally.
- Flush in REQ: assert pfu_pfb_flush while pfu_mmu_req=1. Required: req is held until ack, and the response is suppressed. Entry requests made in the flush cycle while in IDLE are not granted.
- Async reset in WAIT: assert cpurst_b=0. Required: arb_busy=0, pfu_mmu_req=0, grnt=0 with no clock edge. After release, entry 0 has first priority.

Source files
------------

// File: rtl/ct_lsu_pfu_pfb_mmu_pe_arb.sv
// PFB MMU page-entry arbiter: round-robin picks one requesting entry, runs a single
// outstanding MMU translation and returns the result to that entry as a one-hot response.

module ct_lsu_pfu_pfb_mmu_pe_arb_entry (
    input  logic        entry_mmu_pe_req,
    input  logic        entry_pop_vld,
    input  logic        pfu_pfb_flush,
    input  logic [39:0] entry_inst_new_va,
    input  logic [1:0]  entry_priv_mode,
    input  logic [1:0]  entry_mmu_pe_req_src,
    output logic        req_vld,
    output logic [27:0] vpn,
    output logic [1:0]  priv,
    output logic [1:0]  src
);
    // Page offset is irrelevant to translation.
    logic unused_va_lo;
    assign unused_va_lo = ^entry_inst_new_va[11:0];

    assign req_vld = entry_mmu_pe_req & ~entry_pop_vld & ~pfu_pfb_flush;
    assign vpn     = entry_inst_new_va[39:12];
    assign priv    = entry_priv_mode;
    assign src     = entry_mmu_pe_req_src;
endmodule

module ct_lsu_pfu_pfb_mmu_pe_arb #(
    parameter int ENTRY_NUM = 8,
    parameter int ID_W      = 3
) (
    input  logic                    entry_clk,
    input  logic                    cpurst_b,
    input  logic [ENTRY_NUM-1:0]    entry_mmu_pe_req,
    input  logic [2*ENTRY_NUM-1:0]  entry_mmu_pe_req_src,
    input  logic [40*ENTRY_NUM-1:0] entry_inst_new_va,
    input  logic [2*ENTRY_NUM-1:0]  entry_priv_mode,
    input  logic [ENTRY_NUM-1:0]    entry_pop_vld,
    input  logic                    pfu_pfb_flush,
    output logic [ENTRY_NUM-1:0]    entry_mmu_pe_req_grnt,
    output logic                    pfu_mmu_req,
    output logic [27:0]             pfu_mmu_vpn,
    output logic [1:0]              pfu_mmu_priv_mode,
    input  logic                    mmu_pfu_ack,
    input  logic                    mmu_pfu_resp_vld,
    input  logic [27:0]             mmu_pfu_ppn,
    input  logic                    mmu_pfu_fault,
    output logic                    pe_resp_vld,
    output logic [ENTRY_NUM-1:0]    pe_resp_entry_oh,
    output logic [1:0]              pe_resp_src,
    output logic [27:0]             pe_resp_ppn,
    output logic                    pe_resp_fault,
    output logic                    arb_busy
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_t;

    state_t                          state;
    logic [ID_W-1:0]                 rr_ptr;
    logic [ID_W-1:0]                 lat_id;
    logic [1:0]                      lat_src;
    logic                            cancel;

    logic [ENTRY_NUM-1:0]            req_vld;
    logic [ENTRY_NUM-1:0][27:0]      ent_vpn;
    logic [ENTRY_NUM-1:0][1:0]       ent_priv;
    logic [ENTRY_NUM-1:0][1:0]       ent_src;

    logic                            win_vld;
    logic [ID_W-1:0]                 win_id;
    logic [ID_W-1:0]                 cand;
    logic                            kill;

    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
        ct_lsu_pfu_pfb_mmu_pe_arb_entry u_entry (
            .entry_mmu_pe_req     (entry_mmu_pe_req[i]),
            .entry_pop_vld        (entry_pop_vld[i]),
            .pfu_pfb_flush        (pfu_pfb_flush),
            .entry_inst_new_va    (entry_inst_new_va[40*i +: 40]),
            .entry_priv_mode      (entry_priv_mode[2*i +: 2]),
            .entry_mmu_pe_req_src (entry_mmu_pe_req_src[2*i +: 2]),
            .req_vld              (req_vld[i]),
            .vpn                  (ent_vpn[i]),
            .priv                 (ent_priv[i]),
            .src                  (ent_src[i])
        );
    end

    // Search starts just past the last winner; ID_W-bit add wraps modulo ENTRY_NUM.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = 1; k <= ENTRY_NUM; k++) begin
            cand = rr_ptr + ID_W'(k);
            if (!win_vld && req_vld[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    // Owner popped or whole buffer flushed: finish the MMU handshake but drop the answer.
    assign kill     = entry_pop_vld[lat_id] | pfu_pfb_flush;
    assign arb_busy = (state != IDLE);

    always_ff @(posedge entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state                 <= IDLE;
            rr_ptr                <= ID_W'(ENTRY_NUM-1);
            lat_id                <= '0;
            lat_src               <= '0;
            cancel                <= 1'b0;
            entry_mmu_pe_req_grnt <= '0;
            pfu_mmu_req           <= 1'b0;
            pfu_mmu_vpn           <= '0;
            pfu_mmu_priv_mode     <= '0;
            pe_resp_vld           <= 1'b0;
            pe_resp_entry_oh      <= '0;
            pe_resp_src           <= '0;
            pe_resp_ppn           <= '0;
            pe_resp_fault         <= 1'b0;
        end else begin
            entry_mmu_pe_req_grnt <= '0;
            pe_resp_vld           <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state                 <= REQ;
                        lat_id                <= win_id;
                        lat_src               <= ent_src[win_id];
                        pfu_mmu_vpn           <= ent_vpn[win_id];
                        pfu_mmu_priv_mode     <= ent_priv[win_id];
                        rr_ptr                <= win_id;
                        entry_mmu_pe_req_grnt <= ENTRY_NUM'(1) << win_id;
                        pfu_mmu_req           <= 1'b1;
                    end
                end
                REQ: begin
                    if (kill)
                        cancel <= 1'b1;
                    if (mmu_pfu_ack) begin
                        state       <= WAIT;
                        pfu_mmu_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (kill)
                        cancel <= 1'b1;
                    if (mmu_pfu_resp_vld) begin
                        state            <= IDLE;
                        cancel           <= 1'b0;
                        pe_resp_vld      <= ~(cancel | kill);
                        pe_resp_entry_oh <= ENTRY_NUM'(1) << lat_id;
                        pe_resp_src      <= lat_src;
                        pe_resp_ppn      <= mmu_pfu_ppn;
                        pe_resp_fault    <= mmu_pfu_fault;
                    end
                end
                default: begin
                    state       <= IDLE;
                    pfu_mmu_req <= 1'b0;
                    cancel      <= 1'b0;
                end
            endcase
        end
    end
endmodule
